// File: rtl/mult_ctrl_if.sv
// Request/response handshake bundle for mult_ctrl.
// master: the requester that issues multiplies and consumes results.
// slave: the controller (mult_ctrl).
interface mult_ctrl_if #(
    parameter int unsigned TAG_W = 5
);
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic [1:0]       req_op;
    logic [TAG_W-1:0] req_tag;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic [TAG_W-1:0] rsp_tag;

    modport master (
        output req_valid, req_a, req_b, req_op, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_tag
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_tag
    );
endinterface

// File: rtl/mult_ctrl.sv
// Issue/collect controller around a fixed-latency, non-stallable 32x32 unsigned
// multiplier. Operands are converted to magnitudes on issue, per-op metadata
// rides a shift register alongside the multiplier pipeline, and the product is
// sign-corrected, word-selected and buffered in an in-order response FIFO.
// Credit-based admission keeps issued + in-flight + buffered <= FIFO_DEPTH, so
// the FIFO never overflows.
// Build option: define MULT_CTRL_SIGNED_EN for MULH/MULHSU signed handling;
// without it all high-word ops return the unsigned high word.
module mult_ctrl #(
    parameter int unsigned MUL_LAT    = 14,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TAG_W      = 5
) (
    input  logic        clk,
    input  logic        rst,
    mult_ctrl_if.slave  bus,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_p,
    output logic        busy
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef struct packed {
        logic             v;
`ifdef MULT_CTRL_SIGNED_EN
        logic             neg;
`endif
        logic             hi;
        logic [TAG_W-1:0] tag;
    } meta_t;

    typedef struct packed {
        logic [31:0]      word;
        logic [TAG_W-1:0] tag;
    } rsp_t;

    logic        accept;
    logic        pop;
    logic        empty;
    logic        fifo_wr;
    logic [31:0] ma;
    logic [31:0] mb;
`ifdef MULT_CTRL_SIGNED_EN
    logic        sa;
    logic        sb;
    logic        a_neg;
    logic        b_neg;
`endif
    meta_t       tail;
    logic [63:0] full;
    logic [31:0] word;

    meta_t             iss_q, iss_d;
    logic [31:0]       mul_a_q, mul_a_d;
    logic [31:0]       mul_b_q, mul_b_d;
    meta_t             meta_q [MUL_LAT];
    meta_t             meta_d [MUL_LAT];
    rsp_t              mem_q [FIFO_DEPTH];
    rsp_t              mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cred_q, cred_d;

    // Admission depends only on registered credits.
    assign bus.req_ready = (cred_q != '0);
    assign accept        = bus.req_valid & bus.req_ready;

    // Sign decode and conversion of operands to unsigned magnitudes.
    always_comb begin
`ifdef MULT_CTRL_SIGNED_EN
        sa    = (bus.req_op == 2'b01) | (bus.req_op == 2'b10);
        sb    = (bus.req_op == 2'b01);
        a_neg = sa & bus.req_a[31];
        b_neg = sb & bus.req_b[31];
        // 0x80000000 negates to itself, which is its correct unsigned magnitude.
        ma    = a_neg ? (32'd0 - bus.req_a) : bus.req_a;
        mb    = b_neg ? (32'd0 - bus.req_b) : bus.req_b;
`else
        ma    = bus.req_a;
        mb    = bus.req_b;
`endif
    end

    // Issue register: loaded on accept, valid bit drops otherwise.
    always_comb begin
        iss_d   = iss_q;
        iss_d.v = 1'b0;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        if (accept) begin
            iss_d.v   = 1'b1;
            iss_d.hi  = (bus.req_op != 2'b00);
            iss_d.tag = bus.req_tag;
`ifdef MULT_CTRL_SIGNED_EN
            iss_d.neg = a_neg ^ b_neg;
`endif
            mul_a_d   = ma;
            mul_b_d   = mb;
        end
    end

    // Metadata shift register; shifts every cycle in lockstep with the multiplier.
    always_comb begin
        meta_d[0] = iss_q;
        for (int i = 1; i < int'(MUL_LAT); i++) begin
            meta_d[i] = meta_q[i-1];
        end
    end

    // Tail: sign-correct the product and select the result word.
    always_comb begin
        tail = meta_q[MUL_LAT-1];
`ifdef MULT_CTRL_SIGNED_EN
        full = tail.neg ? (64'd0 - mul_p) : mul_p;
`else
        full = mul_p;
`endif
        word    = tail.hi ? full[63:32] : full[31:0];
        fifo_wr = tail.v;
    end

    // Response FIFO and credit counter next state.
    always_comb begin
        empty    = (cnt_q == '0);
        pop      = !empty & bus.rsp_ready;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (fifo_wr) begin
            mem_d[wr_ptr_q] = '{word: word, tag: tail.tag};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({fifo_wr, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        case ({accept, pop})
            2'b10:   cred_d = cred_q - CNT_W'(1);
            2'b01:   cred_d = cred_q + CNT_W'(1);
            default: cred_d = cred_q;
        endcase
    end

    // Busy whenever anything is issued, in flight or buffered.
    always_comb begin
        busy = iss_q.v | !empty;
        for (int i = 0; i < int'(MUL_LAT); i++) begin
            busy = busy | meta_q[i].v;
        end
    end

    assign mul_a         = mul_a_q;
    assign mul_b         = mul_b_q;
    assign bus.rsp_valid = !empty;
    assign bus.rsp_data  = empty ? 32'd0 : mem_q[rd_ptr_q].word;
    assign bus.rsp_tag   = empty ? '0 : mem_q[rd_ptr_q].tag;

    // State registers; reset discards everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_q    <= '0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            for (int i = 0; i < int'(MUL_LAT); i++) begin
                meta_q[i] <= '0;
            end
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            cred_q   <= DEPTH_C;
        end else begin
            iss_q    <= iss_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            meta_q   <= meta_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            cred_q   <= cred_d;
        end
    end
endmodule

// File: tb/tb_mult_ctrl.sv
// Self-checking bench for mult_ctrl: models the 14-cycle multiplier, keeps a
// scoreboard of expected responses pushed at accept and compared at pop.
module tb_mult_ctrl;
    localparam int unsigned MUL_LAT    = 14;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned TAG_W      = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_p;
    logic        busy;

    mult_ctrl_if #(.TAG_W(TAG_W)) bus ();

    mult_ctrl #(
        .MUL_LAT    (MUL_LAT),
        .FIFO_DEPTH (FIFO_DEPTH),
        .TAG_W      (TAG_W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .mul_a (mul_a),
        .mul_b (mul_b),
        .mul_p (mul_p),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Multiplier model: product of cycle c appears in cycle c+MUL_LAT.
    logic [63:0] pipe [MUL_LAT];
    always @(posedge clk) begin
        pipe[0] <= {32'd0, mul_a} * {32'd0, mul_b};
        for (int i = 1; i < int'(MUL_LAT); i++) pipe[i] <= pipe[i-1];
    end
    assign mul_p = pipe[MUL_LAT-1];

    // Response-ready source: directed value or random toggling.
    logic rsp_ready_dir = 1'b1;
    logic rnd_mode = 1'b0;
    logic rnd_ready = 1'b1;
    always @(posedge clk) begin
        #2;
        rnd_ready = ($urandom_range(0, 1) == 1);
    end
    assign bus.rsp_ready = rnd_mode ? rnd_ready : rsp_ready_dir;

    int n_err = 0;
    int n_chk = 0;
    int cyc = 0;
    int last_acc = 0;
    int idx = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
        logic [63:0] p;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] sxa;
        logic [63:0] sxb;
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        sxa = {{32{a[31]}}, a};
        sxb = {{32{b[31]}}, b};
`ifdef MULT_CTRL_SIGNED_EN
        case (op)
            2'b01:   p = sxa * sxb;
            2'b10:   p = sxa * ub;
            default: p = ua * ub;
        endcase
`else
        p = ua * ub;
        if (sxa == 64'd1 && sxb == 64'd1) p = ua * ub;
`endif
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    typedef struct packed {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
    } exp_t;
    exp_t sb_q[$];
    exp_t sb_e;

    // Scoreboard: push on accept, compare on pop; reset flushes expectations.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else begin
            if (bus.req_valid && bus.req_ready)
                sb_q.push_back('{data: model(bus.req_a, bus.req_b, bus.req_op), tag: bus.req_tag});
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_rsp", {63'd0, bus.rsp_valid}, 64'd0);
                end else begin
                    sb_e = sb_q.pop_front();
                    check("sb_data", {32'd0, bus.rsp_data}, {32'd0, sb_e.data});
                    check("sb_tag", {59'd0, bus.rsp_tag}, {59'd0, sb_e.tag});
                end
            end
        end
    end

    // Present one request (called at posedge+1) and hold it until accepted.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                        input logic [TAG_W-1:0] tag);
        int t = 0;
        bus.req_valid = 1'b1;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_op    = op;
        bus.req_tag   = tag;
        forever begin
            @(negedge clk);
            if (bus.req_ready) break;
            t++;
            if (t > 200) begin
                check("send_timeout", 64'd0, 64'd1);
                break;
            end
        end
        last_acc = cyc;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    // Drive requests idx..n-1 for at most max_cyc cycles.
    task automatic drive_n(input int n, input int max_cyc);
        logic acc;
        for (int c = 0; c < max_cyc && idx < n; c++) begin
            bus.req_valid = 1'b1;
            bus.req_a     = 32'(idx + 1);
            bus.req_b     = 32'(idx + 7);
            bus.req_op    = 2'(idx);
            bus.req_tag   = TAG_W'(idx);
            @(negedge clk);
            acc = bus.req_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((sb_q.size() != 0 || busy) && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("drain", {63'd0, (sb_q.size() == 0 && !busy)}, 64'd1);
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp4 [4];
    int          seen;
    int          t;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
`ifdef MULT_CTRL_SIGNED_EN
        exp4[0] = 32'hFFFF_FFFE; exp4[1] = 32'hFFFF_FFFF;
        exp4[2] = 32'hFFFF_FFFF; exp4[3] = 32'h0000_0001;
`else
        exp4[0] = 32'hFFFF_FFFE; exp4[1] = 32'h0000_0001;
        exp4[2] = 32'h0000_0001; exp4[3] = 32'h0000_0001;
`endif
        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        bus.req_tag   = '0;

        // Reset values.
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", {63'd0, bus.req_ready}, 64'd1);
        check("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        check("rst_rsp_data", {32'd0, bus.rsp_data}, 64'd0);
        check("rst_rsp_tag", {59'd0, bus.rsp_tag}, 64'd0);
        check("rst_mul_a", {32'd0, mul_a}, 64'd0);
        check("rst_mul_b", {32'd0, mul_b}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1;

        // Latency of a single op.
        send(32'd3, 32'd5, 2'b00, 5'd1);
        t = 0;
        while (!bus.rsp_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("lat_cycles", 64'(cyc - last_acc), 64'(MUL_LAT + 2));
        check("lat_data", {32'd0, bus.rsp_data}, 64'h0000_000F);
        check("lat_tag", {59'd0, bus.rsp_tag}, 64'd1);
        wait_idle();

        // All four ops back-to-back on the same operands.
        for (int i = 0; i < 4; i++) send(32'hFFFF_FFFF, 32'h0000_0002, 2'(i), TAG_W'(i));
        t = 0;
        while (!bus.rsp_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < 4; i++) begin
            check("b2b_valid", {63'd0, bus.rsp_valid}, 64'd1);
            check("b2b_tag", {59'd0, bus.rsp_tag}, 64'(i));
            check("b2b_data", {32'd0, bus.rsp_data}, {32'd0, exp4[i]});
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        wait_idle();

        // Most-negative operands.
        send(32'h8000_0000, 32'h8000_0000, 2'b01, 5'd8);
        send(32'h8000_0000, 32'h8000_0000, 2'b00, 5'd9);
        wait_idle();

        // Credit exhaustion with the response side stalled.
        rsp_ready_dir = 1'b0;
        idx = 0;
        drive_n(6, 30);
        check("full_accepted", 64'(idx), 64'(FIFO_DEPTH));
        check("full_ready_low", {63'd0, bus.req_ready}, 64'd0);
        rsp_ready_dir = 1'b1;
        drive_n(6, 100);
        check("full_all_accepted", 64'(idx), 64'd6);
        wait_idle();

        // credits=1 with accept and pop in the same cycle.
        rsp_ready_dir = 1'b0;
        for (int i = 0; i < 3; i++) send(32'(i + 2), 32'd11, 2'b11, TAG_W'(20 + i));
        repeat (MUL_LAT + 4) @(negedge clk);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_a     = 32'hDEAD_BEEF;
        bus.req_b     = 32'h1234_5678;
        bus.req_op    = 2'b00;
        bus.req_tag   = 5'd30;
        rsp_ready_dir = 1'b1;
        @(negedge clk);
        check("cred1_ready", {63'd0, bus.req_ready}, 64'd1);
        check("cred1_rsp_valid", {63'd0, bus.rsp_valid}, 64'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        rsp_ready_dir = 1'b0;
        @(negedge clk);
        check("cred1_hold", {63'd0, bus.req_ready}, 64'd1);
        @(posedge clk);
        #1;
        send(32'd6, 32'd7, 2'b00, 5'd31);
        @(negedge clk);
        check("cred0_ready_low", {63'd0, bus.req_ready}, 64'd0);
        rsp_ready_dir = 1'b1;
        @(posedge clk);
        #1;
        wait_idle();

        // Reset with operations in flight.
        for (int i = 0; i < 3; i++) send(32'(100 + i), 32'd3, 2'b00, TAG_W'(i));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_ready", {63'd0, bus.req_ready}, 64'd1);
        check("post_rst_busy", {63'd0, busy}, 64'd0);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        check("post_rst_no_rsp", 64'(seen), 64'd0);
        @(posedge clk);
        #1;
        rsp_ready_dir = 1'b0;
        for (int i = 0; i < 4; i++) send(32'(i + 1), 32'd9, 2'b00, TAG_W'(i));
        @(negedge clk);
        check("post_rst_credits", {63'd0, bus.req_ready}, 64'd0);
        rsp_ready_dir = 1'b1;
        @(posedge clk);
        #1;
        wait_idle();

        // Random mix with randomly stalled responses.
        rnd_mode = 1'b1;
        for (int i = 0; i < 24; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom();
            rb = $urandom();
            if (i % 6 == 0) ra = 32'h8000_0000;
            if (i % 5 == 0) rb = 32'hFFFF_FFFF;
            send(ra, rb, 2'($urandom_range(0, 3)), TAG_W'(i));
        end
        rnd_mode = 1'b0;
        wait_idle();
        check("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/mult_ctrl.md
# mult_ctrl

Issue/collect controller wrapped around the fixed-latency pipelined 32x32 unsigned multiplier. Accepts multiply requests on a valid/ready port and converts signed operands to magnitudes before driving the multiplier. Tracks each operation's metadata alongside the non-stallable multiplier pipeline, then sign-corrects and selects the low or high word of the 64-bit product. Results are buffered in an in-order response FIFO, and credit-based admission guarantees that FIFO can never overflow.

## Interface
- MUL_LAT, 14, multiplier latency in cycles; must match the instantiated multiplier.
- FIFO_DEPTH, 4, response FIFO entries and credit count; power of two, ≥2.
- TAG_W, 5, request tag width.
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready at a rising edge.
- req_a, req_b  in  32  operands.
- req_op  in  2  00 MUL (low word), 01 MULH (s×s high), 10 MULHSU (a signed × b unsigned, high), 11 MULHU (u×u high).
- req_tag  in  TAG_W  returned unchanged with the result.
- mul_a, mul_b  out  32  unsigned magnitudes to the multiplier.
- mul_p  in  64  multiplier product.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready at a rising edge.
- rsp_data  out  32  result word.
- rsp_tag  out  TAG_W  tag of the result.
- busy  out  1  any operation is issued, in flight, or buffered.

## Operation
- Sign decode: sa = (op==01 | op==10); sb = (op==01). Magnitude ma = (sa & a[31]) ? -a : a; same for b. Negation is 32-bit two's complement, so 0x80000000 maps to itself (correct unsigned magnitude). neg = (sa&a[31]) ^ (sb&b[31]).
- Issue register, loaded on accept: {v, ma, mb, neg, hi=(op!=00), tag}. It drives mul_a/mul_b. v clears when there is no accept.
- Metadata shift register, MUL_LAT deep: carries {v, neg, hi, tag} from the issue register. It shifts every cycle and never stalls.
- Tail: full = neg ? -mul_p : mul_p (64-bit). word = hi ? full[63:32] : full[31:0]. When the tail v=1, {word, tag} is written to the FIFO at that edge.
- FIFO: in-order. The head drives rsp_data/rsp_tag, forced to 0 when empty. rsp_valid = !empty. Pop on rsp_valid & rsp_ready.
- Credits: counter 0..FIFO_DEPTH, reset value FIFO_DEPTH. It decrements on accept and increments on pop; when both occur in the same cycle it is unchanged. req_ready = (credits != 0). This bounds issued + in-flight + buffered entries to ≤ FIFO_DEPTH, so a FIFO write never finds the FIFO full.
- busy = issue v | any shift v | !empty.
- Reset (at any time): issue v, all shift v, FIFO pointers and the count clear; credits = FIFO_DEPTH; mul_a/mul_b = 0. Products already in the multiplier are discarded because their v bits are cleared. No response is ever produced for a pre-reset request.
- Reset values: req_ready=1, rsp_valid=0, rsp_data=0, rsp_tag=0, mul_a=0, mul_b=0, busy=0.

## Timing
- Multiplier contract: mul_p in cycle c+MUL_LAT is the product of mul_a/mul_b from cycle c.
- Accept at the end of cycle k → mul_a/mul_b valid in cycle k+1 → FIFO write at the end of cycle k+1+MUL_LAT → rsp_valid in cycle k+MUL_LAT+2 when the FIFO was empty.
- Throughput: one accept per cycle while credits remain. Responses return in accept order.
- req_ready depends only on registered credits; there is no combinational path from req_valid or rsp_ready.

## Configuration
- MULT_CTRL_SIGNED_EN defined: full sign decode and result negation as above.
- MULT_CTRL_SIGNED_EN undefined: sa=sb=neg=0 and the negators are removed. req_op 00 returns the low word; 01/10/11 all return the unsigned high word. Latency is unchanged.

## Test plan
- After reset, op=00, a=3, b=5, tag=1 → rsp_data=0x0000000F, rsp_tag=1, rsp_valid first high exactly MUL_LAT+2 cycles after the accept.
- a=0xFFFFFFFF, b=0x00000002 with ops 00/01/10/11 back-to-back, tags 0..3 → 0xFFFFFFFE, 0xFFFFFFFF, 0xFFFFFFFF, 0x00000001, in tag order on consecutive cycles.
- op=01, a=b=0x80000000 → 0x40000000; op=00 with the same operands → 0x00000000.
- rsp_ready=0, six back-to-back requests → exactly 4 accepted and req_ready low from then on. Raise rsp_ready → tags 0..3 return in order, then the remaining 2 are accepted and returned.
- credits=1, accept and pop in the same cycle → credits stays 1 and req_ready stays high.
- Assert rst for 1 cycle with 3 operations in flight → rsp_valid never rises for them, credits=4, busy=0, req_ready=1 one cycle after rst falls.
